tpx3_rx_packet_assembler: RTL and testbench

Downstream consumer of the Timepix3 receiver core's word FIFO. It pops 32-bit words (7-bit data identifier + 25-bit payload) and pairs each upper-half word with the following lower-half word to rebuild the 48-bit Timepix3 packet. The packet is presented on a valid/ready stream toward the readout FIFO arbiter. It also discards orphaned halves, foreign-header words and stale halves, and counts each case.

---
 rtl/tpx3_rx_packet_assembler.sv | 136 +++++++++++++
 tb/tb_tpx3_rx_packet_assembler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpx3_rx_packet_assembler.sv
// Rebuilds 48-bit Timepix3 packets from pairs of 32-bit receiver FIFO words.
// Orphaned, stale and foreign-header halves are dropped and counted.
module tpx3_rx_packet_assembler #(
    parameter int unsigned DATA_IDENTIFIER = 0,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        ENABLE,
    input  logic        FIFO_EMPTY,
    input  logic [31:0] FIFO_DATA,
    output logic        FIFO_READ,
    output logic [47:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    input  logic        CNT_CLEAR,
    output logic [15:0] PKT_CNT,
    output logic [7:0]  ORPHAN_ERR_CNT,
    output logic [7:0]  HDR_ERR_CNT
);

    localparam logic [6:0]  ID_VALUE = DATA_IDENTIFIER[6:0];
    localparam logic [15:0] TO_VALUE = TIMEOUT[15:0];

    typedef enum logic {
        IDLE,
        HAVE_HIGH
    } state_t;

    state_t      r_state;
    logic [15:0] r_timer;
    logic [23:0] r_hi;
    logic [47:0] r_outData;
    logic        r_outValid;
    logic [15:0] r_pktCnt;
    logic [7:0]  r_orphanCnt;
    logic [7:0]  r_hdrCnt;

    logic        w_outFree;
    logic        w_read;
    logic        w_hdrOk;
    logic        w_goodPop;
    logic        w_badPop;
    logic        w_isHigh;
    logic [15:0] w_timerNext;
    logic        w_timeoutHit;
    logic        w_loadPkt;
    logic        w_orphanInc;

    assign w_outFree    = !r_outValid || OUT_READY;
    assign w_read       = ENABLE && !FIFO_EMPTY && w_outFree && !BUS_RST;
    assign w_hdrOk      = (FIFO_DATA[31:25] == ID_VALUE);
    assign w_goodPop    = w_read && w_hdrOk;
    assign w_badPop     = w_read && !w_hdrOk;
    assign w_isHigh     = FIFO_DATA[24];
    assign w_timerNext  = r_timer + 16'd1;

    // A valid-header pop in the deadline cycle takes priority over the timeout.
    assign w_timeoutHit = (r_state == HAVE_HIGH) && !w_goodPop &&
                          (TO_VALUE != 16'd0) && (w_timerNext == TO_VALUE);
    assign w_loadPkt    = w_goodPop && (r_state == HAVE_HIGH) && !w_isHigh;
    assign w_orphanInc  = (w_goodPop && (r_state == IDLE) && !w_isHigh) ||
                          (w_goodPop && (r_state == HAVE_HIGH) && w_isHigh) ||
                          w_timeoutHit;

    assign FIFO_READ      = w_read;
    assign OUT_DATA       = r_outData;
    assign OUT_VALID      = r_outValid;
    assign PKT_CNT        = r_pktCnt;
    assign ORPHAN_ERR_CNT = r_orphanCnt;
    assign HDR_ERR_CNT    = r_hdrCnt;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_state    <= IDLE;
            r_timer    <= 16'd0;
            r_hi       <= 24'd0;
            r_outData  <= 48'd0;
            r_outValid <= 1'b0;
        end else begin
            if (w_loadPkt) begin
                r_outData  <= {r_hi, FIFO_DATA[23:0]};
                r_outValid <= 1'b1;
            end else if (OUT_READY) begin
                r_outValid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_goodPop && w_isHigh) begin
                        r_hi    <= FIFO_DATA[23:0];
                        r_timer <= 16'd0;
                        r_state <= HAVE_HIGH;
                    end
                end
                HAVE_HIGH: begin
                    if (w_goodPop) begin
                        if (w_isHigh) begin
                            r_hi    <= FIFO_DATA[23:0];
                            r_timer <= 16'd0;
                        end else begin
                            r_timer <= 16'd0;
                            r_state <= IDLE;
                        end
                    end else if (w_timeoutHit) begin
                        r_timer <= 16'd0;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= w_timerNext;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Clear beats a same-cycle increment; error counters saturate, packet count wraps.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || CNT_CLEAR) begin
            r_pktCnt    <= 16'd0;
            r_orphanCnt <= 8'd0;
            r_hdrCnt    <= 8'd0;
        end else begin
            if (w_loadPkt) begin
                r_pktCnt <= r_pktCnt + 16'd1;
            end
            if (w_orphanInc && (r_orphanCnt != 8'hFF)) begin
                r_orphanCnt <= r_orphanCnt + 8'd1;
            end
            if (w_badPop && (r_hdrCnt != 8'hFF)) begin
                r_hdrCnt <= r_hdrCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tpx3_rx_packet_assembler.sv
// Scoreboard bench for tpx3_rx_packet_assembler: directed word sequences feed a
// FIFO model; a monitor checks every accepted packet against the expected queue.
module tb_tpx3_rx_packet_assembler;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic        ENABLE;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;
    logic [47:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        CNT_CLEAR;
    logic [15:0] PKT_CNT;
    logic [7:0]  ORPHAN_ERR_CNT;
    logic [7:0]  HDR_ERR_CNT;

    int          vecCount  = 0;
    int          missCount = 0;
    logic [47:0] expQ[$];
    logic [31:0] fifoMem[0:2047];
    logic [10:0] headPtr = 11'd0;
    logic [10:0] tailPtr = 11'd0;
    logic        prevStalled = 1'b0;
    logic [47:0] prevData = 48'd0;

    tpx3_rx_packet_assembler #(
        .DATA_IDENTIFIER(0),
        .TIMEOUT(8)
    ) dut (
        .BUS_CLK(BUS_CLK),
        .BUS_RST(BUS_RST),
        .ENABLE(ENABLE),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DATA(FIFO_DATA),
        .FIFO_READ(FIFO_READ),
        .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .CNT_CLEAR(CNT_CLEAR),
        .PKT_CNT(PKT_CNT),
        .ORPHAN_ERR_CNT(ORPHAN_ERR_CNT),
        .HDR_ERR_CNT(HDR_ERR_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // First-word-fall-through FIFO model feeding the assembler.
    assign FIFO_EMPTY = (headPtr == tailPtr);
    assign FIFO_DATA  = fifoMem[headPtr];

    always @(posedge BUS_CLK) begin
        if (FIFO_READ) headPtr <= headPtr + 11'd1;
    end

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        fifoMem[tailPtr] = word;
        tailPtr = tailPtr + 11'd1;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (headPtr != tailPtr && guard < 500) begin
            stepCycles(1);
            guard++;
        end
        checkOutput("fifoDrained", 48'(headPtr == tailPtr), 48'd1);
        stepCycles(3);
    endtask

    task automatic clearCounters();
        CNT_CLEAR = 1'b1;
        stepCycles(1);
        CNT_CLEAR = 1'b0;
    endtask

    task automatic checkCounters(input string tag, input int pkt, input int orph, input int hdr);
        checkOutput({tag, "_pkt"}, 48'(PKT_CNT), 48'(pkt));
        checkOutput({tag, "_orphan"}, 48'(ORPHAN_ERR_CNT), 48'(orph));
        checkOutput({tag, "_hdr"}, 48'(HDR_ERR_CNT), 48'(hdr));
    endtask

    // Monitor: pops the scoreboard on each handshake and polices stalls.
    always @(negedge BUS_CLK) begin
        if (OUT_VALID && prevStalled) checkOutput("holdStable", OUT_DATA, prevData);
        if (OUT_VALID && !OUT_READY) checkOutput("stallNoPop", 48'(FIFO_READ), 48'd0);
        if (OUT_VALID && OUT_READY) begin
            if (expQ.size() == 0) begin
                checkOutput("pktExpected", 48'(expQ.size()), 48'd1);
            end else begin
                checkOutput("pktData", OUT_DATA, expQ.pop_front());
            end
        end
        prevStalled <= OUT_VALID && !OUT_READY;
        prevData    <= OUT_DATA;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] hp;
        int guard;
        BUS_RST   = 1'b1;
        ENABLE    = 1'b1;
        OUT_READY = 1'b1;
        CNT_CLEAR = 1'b0;

        // Reset state with a pair already waiting in the FIFO.
        applyStimulus(32'h01000ABC);
        applyStimulus(32'h00000DEF);
        expQ.push_back(48'h000ABC000DEF);
        stepCycles(2);
        checkOutput("rstRead", 48'(FIFO_READ), 48'd0);
        checkOutput("rstValid", 48'(OUT_VALID), 48'd0);
        checkOutput("rstData", OUT_DATA, 48'd0);
        checkCounters("rst", 0, 0, 0);
        BUS_RST = 1'b0;
        stepCycles(1);
        checkOutput("latEarly", 48'(OUT_VALID), 48'd0);
        stepCycles(1);
        checkOutput("latValid", 48'(OUT_VALID), 48'd1);
        checkOutput("latPkt", 48'(PKT_CNT), 48'd1);
        stepCycles(2);

        // Foreign-header word between the halves is discarded.
        applyStimulus(32'h01000123);
        applyStimulus(32'hFE000456);
        applyStimulus(32'h00000456);
        expQ.push_back(48'h000123000456);
        waitDrain();
        checkCounters("pair", 2, 0, 1);

        // Backpressure with four queued pairs.
        clearCounters();
        OUT_READY = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            hp = 24'(i) * 24'h010101;
            applyStimulus({8'h01, hp});
            applyStimulus({8'h00, ~hp});
            expQ.push_back({hp, ~hp});
        end
        guard = 0;
        while (!OUT_VALID && guard < 20) begin
            stepCycles(1);
            guard++;
        end
        checkOutput("bpValid", 48'(OUT_VALID), 48'd1);
        checkOutput("bpQueued", 48'(tailPtr - headPtr), 48'd6);
        stepCycles(10);
        checkOutput("bpStillQueued", 48'(tailPtr - headPtr), 48'd6);
        OUT_READY = 1'b1;
        waitDrain();
        checkCounters("bp", 4, 0, 0);

        // Orphans: L, H, H, L.
        clearCounters();
        applyStimulus(32'h00000001);
        applyStimulus(32'h01AAAAAA);
        applyStimulus(32'h01BBBBBB);
        applyStimulus(32'h00CCCCCC);
        expQ.push_back(48'hBBBBBBCCCCCC);
        waitDrain();
        checkCounters("orphan", 1, 2, 0);

        // Timeout: stale upper half dropped exactly at the deadline.
        clearCounters();
        applyStimulus(32'h01123456);
        stepCycles(8);
        checkOutput("toBefore", 48'(ORPHAN_ERR_CNT), 48'd0);
        stepCycles(1);
        checkOutput("toAfter", 48'(ORPHAN_ERR_CNT), 48'd1);
        stepCycles(11);
        applyStimulus(32'h00654321);
        waitDrain();
        checkCounters("timeout", 0, 2, 0);

        // Lower half popped in the deadline cycle still pairs.
        clearCounters();
        applyStimulus(32'h01111111);
        stepCycles(8);
        applyStimulus(32'h00222222);
        expQ.push_back(48'h111111222222);
        waitDrain();
        checkCounters("toEdge", 1, 0, 0);

        // Timer keeps running while disabled.
        clearCounters();
        applyStimulus(32'h01333333);
        stepCycles(1);
        ENABLE = 1'b0;
        applyStimulus(32'h00444444);
        stepCycles(10);
        checkCounters("disabled", 0, 1, 0);
        checkOutput("disQueued", 48'(tailPtr - headPtr), 48'd1);
        ENABLE = 1'b1;
        waitDrain();
        checkCounters("reenabled", 0, 2, 0);

        // Header error saturation, then clear racing one more bad word.
        clearCounters();
        for (int i = 0; i < 300; i++) applyStimulus(32'hFE000000 | 32'(i));
        waitDrain();
        checkCounters("hdrSat", 0, 0, 255);
        CNT_CLEAR = 1'b1;
        applyStimulus(32'hFE00BEEF);
        stepCycles(1);
        CNT_CLEAR = 1'b0;
        checkOutput("clrPopped", 48'(headPtr == tailPtr), 48'd1);
        checkOutput("clrHdr", 48'(HDR_ERR_CNT), 48'd0);
        stepCycles(1);
        checkOutput("clrHdrHold", 48'(HDR_ERR_CNT), 48'd0);

        // Reset drops a stalled packet and then a held upper half.
        clearCounters();
        OUT_READY = 1'b0;
        applyStimulus(32'h01555555);
        applyStimulus(32'h00666666);
        applyStimulus(32'h01777777);
        stepCycles(2);
        checkOutput("preRstValid", 48'(OUT_VALID), 48'd1);
        checkOutput("preRstPkt", 48'(PKT_CNT), 48'd1);
        BUS_RST = 1'b1;
        stepCycles(1);
        BUS_RST = 1'b0;
        checkOutput("midRstValid", 48'(OUT_VALID), 48'd0);
        checkOutput("midRstData", OUT_DATA, 48'd0);
        checkOutput("midRstPkt", 48'(PKT_CNT), 48'd0);
        stepCycles(1);
        checkOutput("rstHPopped", 48'(headPtr == tailPtr), 48'd1);
        BUS_RST = 1'b1;
        stepCycles(1);
        BUS_RST = 1'b0;
        OUT_READY = 1'b1;
        applyStimulus(32'h00888888);
        waitDrain();
        checkCounters("postRst", 0, 1, 0);

        checkOutput("scoreboardEmpty", 48'(expQ.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
